// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution stream source.
package conv_pkg;

    localparam int WIDTH     = 8;
    localparam int SIZE_X    = 8;
    localparam int LOGSIZE_X = 3;
    localparam int SIZE_F    = 4;
    localparam int LOGSIZE_F = 2;

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } src_state_t;

endpackage

// File: rtl/conv_stream_src_if.sv
// The x and f valid/ready streams feeding the convolution block.
interface conv_stream_src_if;
    import conv_pkg::*;

    sample_t m_data_x;
    logic    m_valid_x;
    logic    m_ready_x;
    sample_t m_data_f;
    logic    m_valid_f;
    logic    m_ready_f;

    modport master (
        output m_data_x, m_valid_x, m_data_f, m_valid_f,
        input  m_ready_x, m_ready_f
    );

    modport slave (
        input  m_data_x, m_valid_x, m_data_f, m_valid_f,
        output m_ready_x, m_ready_f
    );

endinterface

// File: rtl/conv_stream_src_chan.sv
// One stream channel: element buffer, write port, index counter and
// valid/data register. fin goes high in the cycle of the last handshake
// so the controller can leave STREAM without an extra idle cycle.
module stream_chan
    import conv_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int LOGSIZE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  sample_t            wr_data,
    input  logic               launch,
    input  logic               clear,
    input  logic               ready,
    output sample_t            data,
    output logic               valid,
    output logic               fin
);

    sample_t            mem [SIZE];
    logic [LOGSIZE-1:0] idx;
    logic               finished;
    logic               last_hs;

    assign last_hs = valid && ready && (idx == LOGSIZE'(SIZE - 1));
    assign fin     = finished || last_hs;

    // Element buffer: host writes, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Streaming register: present element idx, advance on each handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            valid    <= 1'b0;
            data     <= '0;
            finished <= 1'b0;
        end else if (launch) begin
            idx      <= '0;
            valid    <= 1'b1;
            data     <= mem[0];
            finished <= 1'b0;
        end else if (clear) begin
            idx      <= '0;
            finished <= 1'b0;
        end else if (valid && ready) begin
            if (last_hs) begin
                valid    <= 1'b0;
                finished <= 1'b1;
            end else begin
                idx  <= idx + 1'b1;
                data <= mem[idx + 1'b1];
            end
        end
    end

endmodule

// File: rtl/conv_stream_src.sv
// Stream source for the 8x4 convolution block.
//   state  | meaning
//   IDLE   | accept host writes, wait for start
//   STREAM | both channels sending; leave when both are finished
//   FIN    | one cycle: done pulse, indices returned to 0
module conv_stream_src
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  sample_t              ld_data,
    input  logic [LOGSIZE_X-1:0] ld_addr,
    input  logic                 ld_sel,
    input  logic                 ld_en,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    conv_stream_src_if.master    m
);

    src_state_t state, state_n;
    logic       launch, finish;
    logic       wr_ok, wr_x, wr_f;
    logic       fin_x, fin_f;

    // Writes only in IDLE, and start takes priority over a same-cycle write.
    assign wr_ok = (state == IDLE) && ld_en && !start;
    assign wr_x  = wr_ok && !ld_sel;
    assign wr_f  = wr_ok && ld_sel && (ld_addr < LOGSIZE_X'(SIZE_F));

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and channel control.
    always_comb begin
        state_n = state;
        launch  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = STREAM;
                    launch  = 1'b1;
                end
            end
            STREAM: begin
                if (fin_x && fin_f) state_n = FIN;
            end
            FIN: begin
                state_n = IDLE;
                finish  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    stream_chan #(.SIZE(SIZE_X), .LOGSIZE(LOGSIZE_X)) u_chan_x (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_x),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .launch  (launch),
        .clear   (finish),
        .ready   (m.m_ready_x),
        .data    (m.m_data_x),
        .valid   (m.m_valid_x),
        .fin     (fin_x)
    );

    stream_chan #(.SIZE(SIZE_F), .LOGSIZE(LOGSIZE_F)) u_chan_f (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_f),
        .wr_addr (ld_addr[LOGSIZE_F-1:0]),
        .wr_data (ld_data),
        .launch  (launch),
        .clear   (finish),
        .ready   (m.m_ready_f),
        .data    (m.m_data_f),
        .valid   (m.m_valid_f),
        .fin     (fin_f)
    );

endmodule

// File: tb/tb_conv_stream_src.sv
// Scoreboard bench for conv_stream_src: stimulus pushes expected beats and
// done cycles; negedge monitors pop and compare on every handshake/done.
module tb_conv_stream_src;
    import conv_pkg::*;

    typedef struct {
        sample_t d;
        int      c;   // expected cycle, -1 = untimed
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    sample_t              ld_data;
    logic [LOGSIZE_X-1:0] ld_addr;
    logic                 ld_sel, ld_en, start;
    logic                 busy, done;

    conv_stream_src_if sif ();

    conv_stream_src dut (
        .clk     (clk),
        .reset   (reset),
        .ld_data (ld_data),
        .ld_addr (ld_addr),
        .ld_sel  (ld_sel),
        .ld_en   (ld_en),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .m       (sif)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_exp_cnt = 0;
    exp_t qx[$], qf[$];
    int   qd[$];
    sample_t xexp [SIZE_X];
    sample_t fexp [SIZE_F];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // x channel monitor
    sample_t px; logic pvx = 1'b0, prx = 1'b0;
    always @(negedge clk) begin : mon_x
        exp_t e;
        if (!reset) pvx = 1'b0;
        else begin
            if (pvx && !prx) begin
                chk("x_stall_valid", int'(sif.m_valid_x), 1);
                chk("x_stall_data", int'(sif.m_data_x), int'(px));
            end
            if (sif.m_valid_x && sif.m_ready_x) begin
                if (qx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL x_extra: got beat %0d, expected none", sif.m_data_x);
                end else begin
                    e = qx.pop_front();
                    chk("x_data", int'(sif.m_data_x), int'(e.d));
                    if (e.c >= 0) chk("x_cycle", cyc, e.c);
                end
            end
            pvx = sif.m_valid_x; prx = sif.m_ready_x; px = sif.m_data_x;
        end
    end

    // f channel monitor
    sample_t pf; logic pvf = 1'b0, prf = 1'b0;
    always @(negedge clk) begin : mon_f
        exp_t e;
        if (!reset) pvf = 1'b0;
        else begin
            if (pvf && !prf) begin
                chk("f_stall_valid", int'(sif.m_valid_f), 1);
                chk("f_stall_data", int'(sif.m_data_f), int'(pf));
            end
            if (sif.m_valid_f && sif.m_ready_f) begin
                if (qf.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL f_extra: got beat %0d, expected none", sif.m_data_f);
                end else begin
                    e = qf.pop_front();
                    chk("f_data", int'(sif.m_data_f), int'(e.d));
                    if (e.c >= 0) chk("f_cycle", cyc, e.c);
                end
            end
            pvf = sif.m_valid_f; prf = sif.m_ready_f; pf = sif.m_data_f;
        end
    end

    // done monitor
    always @(negedge clk) begin : mon_done
        int e;
        if (reset && done) begin
            done_cnt++;
            if (qd.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_extra: got done at cycle %0d, expected none", cyc);
            end else begin
                e = qd.pop_front();
                if (e >= 0) chk("done_cycle", cyc, e);
                chk("done_x_drained", qx.size(), 0);
                chk("done_f_drained", qf.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input int addr, input int val);
        ld_en = 1'b1; ld_sel = sel; ld_addr = LOGSIZE_X'(addr); ld_data = sample_t'(val);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_xfer(input int s, input bit timed);
        for (int k = 0; k < SIZE_X; k++) qx.push_back('{xexp[k], timed ? s + 1 + k : -1});
        for (int k = 0; k < SIZE_F; k++) qf.push_back('{fexp[k], timed ? s + 1 + k : -1});
        qd.push_back(timed ? s + 9 : -1);
        done_exp_cnt++;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        chk("done_seen", int'(seen), 1);
    endtask

    initial begin
        int s, s1;
        bit seen;
        reset = 1'b1; ld_en = 0; ld_sel = 0; ld_addr = '0; ld_data = '0; start = 0;
        sif.m_ready_x = 1'b0; sif.m_ready_f = 1'b0;
        #2 reset = 1'b0;
        #10;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_valid_x", int'(sif.m_valid_x), 0);
        chk("reset_valid_f", int'(sif.m_valid_f), 0);
        chk("reset_data_x", int'(sif.m_data_x), 0);
        chk("reset_data_f", int'(sif.m_data_f), 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Basic transfer, readies held high.
        for (int k = 0; k < SIZE_X; k++) begin xexp[k] = sample_t'(k + 1); load(1'b0, k, k + 1); end
        fexp[0] = -1; fexp[1] = 2; fexp[2] = -3; fexp[3] = 4;
        for (int k = 0; k < SIZE_F; k++) load(1'b1, k, int'(fexp[k]));
        sif.m_ready_x = 1'b1; sif.m_ready_f = 1'b1;
        do_start(s);
        expect_xfer(s, 1'b1);
        chk("busy_after_start", int'(busy), 1);
        wait_done(30);
        chk("busy_in_fin", int'(busy), 1);
        tick();
        chk("busy_after_fin", int'(busy), 0);
        chk("idle_valid_x", int'(sif.m_valid_x), 0);
        chk("idle_valid_f", int'(sif.m_valid_f), 0);
        chk("hold_data_x", int'(sif.m_data_x), 8);
        chk("hold_data_f", int'(sif.m_data_f), 4);

        // Backpressure: x toggles, f stalled for 10 cycles.
        sif.m_ready_x = 1'b1; sif.m_ready_f = 1'b0;
        do_start(s);
        expect_xfer(s, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            sif.m_ready_x = (i % 2 == 0);
            sif.m_ready_f = (i >= 10);
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("stall_done_seen", int'(seen), 1);
        sif.m_ready_x = 1'b1; sif.m_ready_f = 1'b1;

        // start and write while busy are ignored.
        do_start(s);
        expect_xfer(s, 1'b1);
        start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 99;
        tick();
        start = 1'b0; ld_en = 1'b0;
        wait_done(30);
        tick();
        do_start(s);
        expect_xfer(s, 1'b1);
        wait_done(30);
        tick();

        // Dropped f write at addr 6, then start together with an x write.
        load(1'b1, 6, 77);
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3'd2; ld_data = 55;
        do_start(s);
        ld_en = 1'b0;
        expect_xfer(s, 1'b1);
        wait_done(30);
        tick();

        // Back-to-back transfers, start in the cycle after done.
        do_start(s1);
        expect_xfer(s1, 1'b1);
        wait_done(30);
        tick();
        do_start(s);
        expect_xfer(s, 1'b1);
        wait_done(30);
        tick();

        // Asynchronous reset after 3 x beats.
        do_start(s);
        for (int k = 0; k < 3; k++) begin
            qx.push_back('{xexp[k], s + 1 + k});
            qf.push_back('{fexp[k], s + 1 + k});
        end
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_valid_x", int'(sif.m_valid_x), 0);
        chk("arst_valid_f", int'(sif.m_valid_f), 0);
        chk("arst_data_x", int'(sif.m_data_x), 0);
        chk("arst_data_f", int'(sif.m_data_f), 0);
        chk("arst_x_beats", qx.size(), 0);
        chk("arst_f_beats", qf.size(), 0);
        qx.delete(); qf.delete();
        @(posedge clk); #1 reset = 1'b1;
        tick();
        for (int k = 0; k < SIZE_X; k++) xexp[k] = '0;
        for (int k = 0; k < SIZE_F; k++) fexp[k] = '0;
        do_start(s);
        expect_xfer(s, 1'b1);
        wait_done(30);
        tick(); tick();

        chk("done_count", done_cnt, done_exp_cnt);
        chk("final_x_queue", qx.size(), 0);
        chk("final_f_queue", qf.size(), 0);
        chk("final_done_queue", qd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
